// File: rtl/ram_pkg.sv
// Shared types and helpers for the multi-port RAM family.
package ram_pkg;

    localparam int unsigned MAX_RD_PORTS = 8;

    typedef logic wr_port_t;

    localparam wr_port_t WR_PORT0 = 1'b0;
    localparam wr_port_t WR_PORT1 = 1'b1;

    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/ram1r1w.sv
// Single-read, single-write bank; registered read, old data on read-during-write.
module ram1r1w #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned LG_DEPTH = 6
) (
    input  logic                clk,
    input  logic                re,
    input  logic [LG_DEPTH-1:0] raddr,
    output logic [WIDTH-1:0]    rdata,
    input  logic                we,
    input  logic [LG_DEPTH-1:0] waddr,
    input  logic [WIDTH-1:0]    wdata
);

    logic [WIDTH-1:0] mem [2**LG_DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ram_lvt.sv
// Live-value table: one bit per entry recording which write port last wrote it.
module ram_lvt
    import ram_pkg::*;
#(
    parameter int unsigned LG_DEPTH = 6,
    parameter int unsigned NUM_RD   = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [1:0]                 wr_en,
    input  logic [2*LG_DEPTH-1:0]      wr_addr,
    input  logic [NUM_RD*LG_DEPTH-1:0] rd_addr,
    output logic [NUM_RD-1:0]          rd_sel
);

    localparam int unsigned DEPTH = 2**LG_DEPTH;

    logic [DEPTH-1:0]  lvt_q;
    logic [NUM_RD-1:0] sel_q;

    // Port 1 is applied last so it wins a same-address collision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lvt_q <= '0;
        end else begin
            if (wr_en[0]) lvt_q[wr_addr[slice_lo(0, LG_DEPTH) +: LG_DEPTH]] <= WR_PORT0;
            if (wr_en[1]) lvt_q[wr_addr[slice_lo(1, LG_DEPTH) +: LG_DEPTH]] <= WR_PORT1;
        end
    end

    // Samples the pre-update table, matching the banks' old-data reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q <= '0;
        end else begin
            for (int r = 0; r < NUM_RD; r++) begin
                sel_q[r] <= lvt_q[rd_addr[slice_lo(r, LG_DEPTH) +: LG_DEPTH]];
            end
        end
    end

    assign rd_sel = sel_q;

endmodule

// File: rtl/ram_nr2w_lvt.sv
// NUM_RD-read / 2-write RAM built from ram1r1w banks plus a live-value table.
// Define RAM_NR2W_WR_BYPASS_EN for write-first read-during-write behaviour.
module ram_nr2w_lvt
    import ram_pkg::*;
#(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned LG_DEPTH = 6,
    parameter int unsigned NUM_RD   = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*LG_DEPTH-1:0] rd_addr,
    output logic [NUM_RD*WIDTH-1:0]    rd_data,
    output logic [NUM_RD-1:0]          rd_valid,
    input  logic [1:0]                 wr_en,
    input  logic [2*LG_DEPTH-1:0]      wr_addr,
    input  logic [2*WIDTH-1:0]         wr_data
);

    if (NUM_RD < 1 || NUM_RD > MAX_RD_PORTS) begin : g_bad_num_rd
        $error("ram_nr2w_lvt: NUM_RD out of range");
    end

    logic [WIDTH-1:0]  bank_rdata [2][NUM_RD];
    logic [WIDTH-1:0]  mux_data   [NUM_RD];
    logic [NUM_RD-1:0] lvt_sel;
    logic [NUM_RD-1:0] rd_valid_q;

    for (genvar w = 0; w < 2; w++) begin : g_wr
        for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
            ram1r1w #(
                .WIDTH    (WIDTH),
                .LG_DEPTH (LG_DEPTH)
            ) u_bank (
                .clk   (clk),
                .re    (rd_en[r]),
                .raddr (rd_addr[r*LG_DEPTH +: LG_DEPTH]),
                .rdata (bank_rdata[w][r]),
                .we    (wr_en[w]),
                .waddr (wr_addr[w*LG_DEPTH +: LG_DEPTH]),
                .wdata (wr_data[w*WIDTH +: WIDTH])
            );
        end
    end

    ram_lvt #(
        .LG_DEPTH (LG_DEPTH),
        .NUM_RD   (NUM_RD)
    ) u_lvt (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .rd_addr (rd_addr),
        .rd_sel  (lvt_sel)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_valid_q <= '0;
        else          rd_valid_q <= rd_en;
    end

`ifdef RAM_NR2W_WR_BYPASS_EN
    logic [NUM_RD-1:0] byp_hit_d, byp_hit_q;
    logic [WIDTH-1:0]  byp_data_d [NUM_RD];
    logic [WIDTH-1:0]  byp_data_q [NUM_RD];

    always_comb begin
        for (int r = 0; r < NUM_RD; r++) begin
            byp_hit_d[r]  = 1'b0;
            byp_data_d[r] = byp_data_q[r];
            if (rd_en[r] && wr_en[1] && (rd_addr[slice_lo(r, LG_DEPTH) +: LG_DEPTH] ==
                                         wr_addr[slice_lo(1, LG_DEPTH) +: LG_DEPTH])) begin
                byp_hit_d[r]  = 1'b1;
                byp_data_d[r] = wr_data[slice_lo(1, WIDTH) +: WIDTH];
            end else if (rd_en[r] && wr_en[0] &&
                         (rd_addr[slice_lo(r, LG_DEPTH) +: LG_DEPTH] ==
                          wr_addr[slice_lo(0, LG_DEPTH) +: LG_DEPTH])) begin
                byp_hit_d[r]  = 1'b1;
                byp_data_d[r] = wr_data[slice_lo(0, WIDTH) +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) byp_hit_q <= '0;
        else          byp_hit_q <= byp_hit_d;
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_RD; r++) byp_data_q[r] <= byp_data_d[r];
    end
`endif

    always_comb begin
        rd_data = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            mux_data[r] = lvt_sel[r] ? bank_rdata[1][r] : bank_rdata[0][r];
`ifdef RAM_NR2W_WR_BYPASS_EN
            if (byp_hit_q[r]) mux_data[r] = byp_data_q[r];
`endif
            if (rd_valid_q[r]) rd_data[slice_lo(r, WIDTH) +: WIDTH] = mux_data[r];
        end
    end

    assign rd_valid = rd_valid_q;

endmodule
